mult_share_arbiter: RTL and testbench
=====================================

// Module: mult_share_arbiter
// PURPOSE
//  Shares one combinational 32-bit multiplier (operands a,b -> result, ovf) between NUM_REQ requesters.
//  Requesters are neuron datapaths issuing weight*input products.
//  Per-requester valid/ready request and response channels; round-robin grant; one product in flight.
//  Operands are registered toward the multiplier; result is captured after MUL_LAT cycles and returned
//  to the granted requester. Per-requester sticky overflow flags are kept for the neuron controllers.
// PARAMETERS
//  NUM_REQ  2   number of requesters, 2..8
//  DATA_W   32  operand/result width; must match the multiplier
//  MUL_LAT  1   cycles from operand register update to result capture, 1..4
// PORTS
//  clk          in   1              clock, rising edge
//  rst_n        in   1              reset, asynchronous, active-low
//  req_valid    in   NUM_REQ        request valid, one bit per requester
//  req_ready    out  NUM_REQ        request accepted this cycle (one-hot or zero)
//  req_a        in   NUM_REQ*DATA_W operand a; requester i at [i*DATA_W +: DATA_W]
//  req_b        in   NUM_REQ*DATA_W operand b; same packing as req_a
//  rsp_valid    out  NUM_REQ        response valid, one-hot or zero
//  rsp_ready    in   NUM_REQ        response accepted by requester
//  rsp_result   out  DATA_W         product; valid for the requester with rsp_valid set
//  rsp_ovf      out  1              overflow of this product
//  mul_a,mul_b  out  DATA_W         registered operands to the multiplier
//  mul_result   in   DATA_W         multiplier result
//  mul_ovf      in   1              multiplier overflow
//  ovf_sticky   out  NUM_REQ        per-requester overflow flag, set on overflow
//  ovf_clr      in   NUM_REQ        clears the matching ovf_sticky bit
//  busy         out  1              high in any state other than IDLE
// BEHAVIOUR
//  Reset (rst_n low, asynchronous): state IDLE, rr pointer = NUM_REQ-1 (requester 0 has first priority).
//    All outputs are 0 while rst_n is low, including the combinational req_ready.
//  FSM states IDLE -> EXEC -> RESP -> IDLE.
//  IDLE:
//    - g = first i with req_valid[i] set, scanning from (ptr+1) mod NUM_REQ upward with wrap.
//    - req_ready[g] is asserted combinationally in the same cycle.
//    - On that edge: mul_a/mul_b <= req_a/req_b of g; grant_idx <= g; cnt <= MUL_LAT; next state EXEC.
//    - No req_valid: stay in IDLE, req_ready = 0.
//  EXEC:
//    - req_ready = 0; cnt decrements each cycle.
//    - In the cycle where cnt==1: rsp_result <= mul_result; rsp_ovf <= mul_ovf; next state RESP.
//    - Issue-to-capture latency is exactly MUL_LAT cycles.
//  RESP:
//    - rsp_valid[grant_idx] = 1; rsp_result/rsp_ovf held stable until rsp_ready[grant_idx].
//    - On handshake: ptr <= grant_idx; next state IDLE.
//    - rsp_ready on other bits is ignored.
//  Throughput: at best one product per MUL_LAT+2 cycles; requests are never accepted in EXEC or RESP.
//  Request rules:
//    - req_valid may drop before a grant with no effect.
//    - Operands are sampled only at the accepting edge.
//  mul_a/mul_b hold their last values outside issue; no spurious multiplier toggling.
//  ovf_sticky[i]:
//    - Set at the capture edge when grant_idx==i and mul_ovf==1.
//    - Cleared by ovf_clr[i]; simultaneous set and clear -> set wins.
//  Width: products are not truncated or extended here; result and ovf pass through from the multiplier.
//  Reset mid-operation abandons the product. No response is issued and the sticky flags clear.
// STRUCTURE
//  Shared package mult_arb_pkg:
//    - FSM state encoding (IDLE=0, EXEC=1, RESP=2).
//    - Default DATA_W and MUL_LAT constants.
//    - Index width function clog2(NUM_REQ).
//  Sub-module rr_arbiter (NUM_REQ): inputs req vector and ptr; outputs one-hot grant, grant index, any.
//  The multiplier is instantiated by the parent; this block only drives and samples its ports.
// TESTING (bench stub multiplier: result = low 32 bits of a*b, ovf = |upper 32 bits)
//  1. Single request: req0 a=3 b=5 -> req_ready[0] in the same cycle; rsp_valid[0] MUL_LAT+1 cycles later;
//     result=15, ovf=0; busy low after the handshake.
//  2. Contention: req0 and req1 held valid with 7*6 and 9*9 -> grants alternate 0,1,0,1.
//     Responses are 42 then 81; no requester is granted twice in a row while the other waits.
//  3. Overflow: a=0x00010000 b=0x00010000 -> result 0, rsp_ovf=1, ovf_sticky[0]=1.
//     ovf_clr[0] in the same cycle as a new overflow leaves the flag set; ovf_clr alone clears it.
//  4. Backpressure: rsp_ready[1] held low 10 cycles -> rsp_valid/rsp_result stay stable.
//     req0 is not accepted until the response handshake completes.
//  5. Reset mid-EXEC with MUL_LAT=4: rst_n low at cnt==2.
//     -> all outputs 0 immediately, no response afterward; next grant goes to requester 0.
//  6. Sweep MUL_LAT 1..4 -> issue-to-rsp_valid distance is MUL_LAT+1 cycles.

Source files
------------

// File: rtl/mult_share_arbiter_pkg.sv
// Shared types and constants for the multiplier-sharing arbiter.
// State encoding, default widths/latency and the requester index width helper.
package mult_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_MUL_LAT = 1;

  // Width of an index into n requesters, never less than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Request/response channels between the neuron datapaths and the multiplier arbiter.
// master = requester side, slave = arbiter side.
interface mult_share_arbiter_if
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = DEF_DATA_W
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ-1:0]        rsp_ready;
  logic [DATA_W-1:0]         rsp_result;
  logic                      rsp_ovf;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_ovf
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_ovf
  );
endinterface

// File: rtl/mult_share_arbiter_rr_arbiter.sv
// Round-robin picker: first set request scanning upward from ptr+1 with wrap.
// Purely combinational; grant is one-hot or zero.
module rr_arbiter
  import mult_arb_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int IW      = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      gnt_idx,
  output logic               any
);

  always_comb begin
    logic [IW-1:0] idx;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IW'((int'(ptr) + k) % NUM_REQ);
      if (!any && req[idx]) begin
        any      = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one combinational multiplier between NUM_REQ requesters, one product in flight.
// Accept in IDLE, capture after MUL_LAT cycles, hold the response until the granted requester takes it.
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MUL_LAT = DEF_MUL_LAT
) (
  input  logic                clk,
  input  logic                rst_n,
  mult_share_arbiter_if.slave bus,
  output logic [DATA_W-1:0]   mul_a,
  output logic [DATA_W-1:0]   mul_b,
  input  logic [DATA_W-1:0]   mul_result,
  input  logic                mul_ovf,
  output logic [NUM_REQ-1:0]  ovf_sticky,
  input  logic [NUM_REQ-1:0]  ovf_clr,
  output logic                busy
);

  localparam int IW = clog2(NUM_REQ);
  localparam int CW = 3;

  arb_state_t          state;
  logic [IW-1:0]       ptr;
  logic [IW-1:0]       grant_idx;
  logic [IW-1:0]       arb_idx;
  logic [NUM_REQ-1:0]  arb_gnt;
  logic [NUM_REQ-1:0]  grant_oh;
  logic [NUM_REQ-1:0]  rsp_valid_q;
  logic                arb_any;
  logic                capture;
  logic [CW-1:0]       cnt;
  logic [DATA_W-1:0]   sel_a;
  logic [DATA_W-1:0]   sel_b;
  logic [DATA_W-1:0]   rsp_result_q;
  logic                rsp_ovf_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req     (bus.req_valid),
    .ptr     (ptr),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx),
    .any     (arb_any)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == IW'(i)) begin
        sel_a = bus.req_a[i*DATA_W +: DATA_W];
        sel_b = bus.req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  assign grant_oh = NUM_REQ'(1) << grant_idx;
  assign capture  = (state == EXEC) && (cnt == CW'(1));

  // Gated by rst_n so that nothing looks accepted while reset is asserted.
  assign bus.req_ready  = (rst_n && state == IDLE) ? arb_gnt : '0;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_ovf    = rsp_ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      ptr          <= IW'(NUM_REQ - 1);
      grant_idx    <= '0;
      cnt          <= '0;
      mul_a        <= '0;
      mul_b        <= '0;
      rsp_result_q <= '0;
      rsp_ovf_q    <= 1'b0;
      rsp_valid_q  <= '0;
      busy         <= 1'b0;
      ovf_sticky   <= '0;
    end else begin
      // A set on the capture edge overrides a clear of the same bit.
      ovf_sticky <= (ovf_sticky & ~ovf_clr) | ((capture && mul_ovf) ? grant_oh : '0);
      case (state)
        IDLE: begin
          if (arb_any) begin
            mul_a     <= sel_a;
            mul_b     <= sel_b;
            grant_idx <= arb_idx;
            cnt       <= CW'(MUL_LAT);
            busy      <= 1'b1;
            state     <= EXEC;
          end
        end
        EXEC: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            rsp_result_q <= mul_result;
            rsp_ovf_q    <= mul_ovf;
            rsp_valid_q  <= grant_oh;
            state        <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready[grant_idx]) begin
            ptr         <= grant_idx;
            rsp_valid_q <= '0;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: four instances with MUL_LAT 1..4 share one stimulus,
// one instance at a time is checked against a transaction-level round-robin model.
module tb_mult_share_arbiter;
  import mult_arb_pkg::*;

  localparam int NR = 3;
  localparam int DW = 32;
  localparam int NI = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR-1:0]    req_valid, rsp_ready, ovf_clr;
  logic [NR*DW-1:0] req_a, req_b;

  logic [NI-1:0][NR-1:0] req_ready_v, rsp_valid_v, ovf_sticky_v;
  logic [NI-1:0][DW-1:0] rsp_result_v, mul_a_v, mul_b_v;
  logic [NI-1:0]         rsp_ovf_v, busy_v;

  for (genvar k = 0; k < NI; k++) begin : g_dut
    mult_share_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();
    logic [2*DW-1:0] prod;

    assign bus.req_valid   = req_valid;
    assign bus.req_a       = req_a;
    assign bus.req_b       = req_b;
    assign bus.rsp_ready   = rsp_ready;
    assign req_ready_v[k]  = bus.req_ready;
    assign rsp_valid_v[k]  = bus.rsp_valid;
    assign rsp_result_v[k] = bus.rsp_result;
    assign rsp_ovf_v[k]    = bus.rsp_ovf;
    // Stub multiplier: low word of the full product, overflow if any upper bit is set.
    assign prod = {{DW{1'b0}}, mul_a_v[k]} * {{DW{1'b0}}, mul_b_v[k]};

    mult_share_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MUL_LAT(k + 1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .mul_a      (mul_a_v[k]),
      .mul_b      (mul_b_v[k]),
      .mul_result (prod[DW-1:0]),
      .mul_ovf    (|prod[2*DW-1:DW]),
      .ovf_sticky (ovf_sticky_v[k]),
      .ovf_clr    (ovf_clr),
      .busy       (busy_v[k])
    );
  end

  int tests = 0;
  int fails = 0;
  int sel   = 0;
  int ptr_m;
  logic [NR-1:0] sticky_m;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int grant_m();
    for (int k = 1; k <= NR; k++)
      if (req_valid[(ptr_m + k) % NR]) return (ptr_m + k) % NR;
    return -1;
  endfunction

  task automatic do_reset(input int s);
    sel = s;
    rst_n = 1'b0;
    req_valid = '0; rsp_ready = '0; ovf_clr = '0; req_a = '0; req_b = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ptr_m = NR - 1;
    sticky_m = '0;
  endtask

  // One full transaction from the cycle the request is presented to the response handshake.
  task automatic run_txn(input int hold, input logic [NR-1:0] clr_cap,
                         input logic [NR-1:0] post_valid, input bit rand_post, input string tag);
    int g, lat;
    logic [NR-1:0] g_oh;
    logic [DW-1:0] a, b;
    logic [2*DW-1:0] p;
    lat = sel + 1;
    g = grant_m();
    g_oh = NR'(1) << g;
    a = req_a[g*DW +: DW];
    b = req_b[g*DW +: DW];
    p = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
    @(negedge clk);
    check({tag, ":grant"}, req_ready_v[sel], g_oh);
    check({tag, ":idle_busy"}, busy_v[sel], 0);
    @(posedge clk); #1;
    if (rand_post) begin
      req_valid = NR'($urandom);
      for (int i = 0; i < NR; i++) begin
        req_a[i*DW +: DW] = $urandom;
        req_b[i*DW +: DW] = $urandom;
      end
    end else begin
      req_valid = post_valid;
    end
    for (int c = 1; c <= lat; c++) begin
      if (c == lat) ovf_clr = clr_cap;
      @(negedge clk);
      check({tag, ":exec_rsp_valid"}, rsp_valid_v[sel], 0);
      check({tag, ":exec_req_ready"}, req_ready_v[sel], 0);
      check({tag, ":exec_busy"}, busy_v[sel], 1);
      check({tag, ":mul_ops"}, {mul_a_v[sel], mul_b_v[sel]}, {a, b});
      @(posedge clk); #1;
      ovf_clr = '0;
    end
    sticky_m = (sticky_m & ~clr_cap) | ((|p[2*DW-1:DW]) ? g_oh : '0);
    for (int h = 0; h <= hold; h++) begin
      rsp_ready = (h == hold) ? g_oh : (NR'($urandom) & ~g_oh);
      @(negedge clk);
      check({tag, ":rsp_valid"}, rsp_valid_v[sel], g_oh);
      check({tag, ":rsp_result"}, rsp_result_v[sel], p[DW-1:0]);
      check({tag, ":rsp_ovf"}, rsp_ovf_v[sel], |p[2*DW-1:DW]);
      check({tag, ":resp_req_ready"}, req_ready_v[sel], 0);
      check({tag, ":sticky"}, ovf_sticky_v[sel], sticky_m);
      @(posedge clk); #1;
    end
    rsp_ready = '0;
    ptr_m = g;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with requests pending to confirm req_ready is held low.
    req_valid = '1; rsp_ready = '0; ovf_clr = '0; req_a = '1; req_b = '1;
    #2;
    for (int s = 0; s < NI; s++) begin
      check("rst:req_ready", req_ready_v[s], 0);
      check("rst:rsp_valid", rsp_valid_v[s], 0);
      check("rst:outs", {rsp_result_v[s], rsp_ovf_v[s], busy_v[s]}, 0);
      check("rst:mul", {mul_a_v[s], mul_b_v[s]}, 0);
      check("rst:sticky", ovf_sticky_v[s], 0);
    end

    // Single request at every latency: 3*5, response MUL_LAT+1 cycles after acceptance.
    for (int s = 0; s < NI; s++) begin
      do_reset(s);
      req_valid = 3'b001;
      req_a[0 +: DW] = 3; req_b[0 +: DW] = 5;
      run_txn(0, '0, '0, 0, "single");
      check("single:15", rsp_result_v[sel], 15);
      @(negedge clk);
      check("single:busy_after", busy_v[sel], 0);
      check("single:no_rsp_after", rsp_valid_v[sel], 0);
      @(posedge clk); #1;
    end

    // Contention: two requesters held valid must alternate 0,1,0,1.
    do_reset(1);
    req_valid = 3'b011;
    req_a[0 +: DW] = 7; req_b[0 +: DW] = 6;
    req_a[DW +: DW] = 9; req_b[DW +: DW] = 9;
    for (int n = 0; n < 4; n++) begin
      run_txn(n, '0, 3'b011, 0, "contend");
      check("contend:order", rsp_result_v[sel], (n % 2 == 1) ? 81 : 42);
    end

    // Overflow and sticky flag set/clear priority.
    do_reset(1);
    req_valid = 3'b001;
    req_a[0 +: DW] = 32'h0001_0000; req_b[0 +: DW] = 32'h0001_0000;
    run_txn(0, '0, '0, 0, "ovf");
    check("ovf:result0", {rsp_result_v[sel], rsp_ovf_v[sel]}, {32'h0, 1'b1});
    check("ovf:sticky", ovf_sticky_v[sel], 3'b001);
    req_valid = 3'b001;
    run_txn(2, 3'b001, '0, 0, "ovf_clrset");
    check("ovf:set_wins", ovf_sticky_v[sel], 3'b001);
    ovf_clr = 3'b001;
    @(posedge clk); #1;
    ovf_clr = '0;
    sticky_m = '0;
    @(negedge clk);
    check("ovf:clr", ovf_sticky_v[sel], 0);
    @(posedge clk); #1;

    // Backpressure: requester 1 stalls its response 10 cycles while requester 0 waits.
    do_reset(2);
    req_valid = 3'b010;
    req_a[0 +: DW] = 2; req_b[0 +: DW] = 4;
    req_a[DW +: DW] = 11; req_b[DW +: DW] = 13;
    run_txn(10, '0, 3'b011, 0, "bp");
    check("bp:held", rsp_result_v[sel], 143);
    run_txn(0, '0, '0, 0, "bp_next");
    check("bp:next_result", rsp_result_v[sel], 8);

    // Reset in the middle of EXEC with MUL_LAT=4 at cnt==2.
    do_reset(3);
    req_valid = 3'b001;
    req_a[0 +: DW] = 32'h0001_0003; req_b[0 +: DW] = 32'h0001_0000;
    run_txn(0, '0, '0, 0, "r5ovf");
    req_valid = 3'b010;
    req_a[DW +: DW] = 5; req_b[DW +: DW] = 6;
    @(negedge clk);
    check("r5:grant1", req_ready_v[sel], 3'b010);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("r5:req_ready", req_ready_v[sel], 0);
    check("r5:rsp_valid", rsp_valid_v[sel], 0);
    check("r5:outs", {rsp_result_v[sel], rsp_ovf_v[sel], busy_v[sel]}, 0);
    check("r5:mul", {mul_a_v[sel], mul_b_v[sel]}, 0);
    check("r5:sticky", ovf_sticky_v[sel], 0);
    @(posedge clk); #1;
    req_valid = '0;
    rst_n = 1'b1;
    ptr_m = NR - 1;
    sticky_m = '0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("r5:no_rsp", {rsp_valid_v[sel], busy_v[sel]}, 0);
      @(posedge clk); #1;
    end
    req_valid = 3'b011;
    run_txn(0, '0, '0, 0, "r5after");
    check("r5:first_is_0", rsp_result_v[sel], 32'h0003_0000);

    // Randomized traffic on every latency against the model.
    for (int s = 0; s < NI; s++) begin
      do_reset(s);
      for (int t = 0; t < 40; t++) begin
        logic [NR-1:0] clr;
        req_valid = NR'($urandom);
        for (int i = 0; i < NR; i++) begin
          req_a[i*DW +: DW] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 65535));
          req_b[i*DW +: DW] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 65535));
        end
        if (req_valid == '0) begin
          @(negedge clk);
          check("rand:idle", {req_ready_v[sel], busy_v[sel]}, 0);
          @(posedge clk); #1;
        end else begin
          clr = ($urandom_range(0, 3) == 0) ? NR'($urandom) : '0;
          run_txn($urandom_range(0, 3), clr, '0, 1, "rand");
        end
        if ($urandom_range(0, 4) == 0) begin
          req_valid = '0;
          ovf_clr = NR'($urandom);
          @(negedge clk);
          check("rand:sticky_pre", ovf_sticky_v[sel], sticky_m);
          @(posedge clk); #1;
          sticky_m = sticky_m & ~ovf_clr;
          ovf_clr = '0;
          @(negedge clk);
          check("rand:sticky_clr", ovf_sticky_v[sel], sticky_m);
          @(posedge clk); #1;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
